// File: rtl/seg_pattern_reader.sv
// Receives a multiplexed active-low 7-segment bus, debounces each digit pattern,
// inverse-decodes it to hex and assembles complete multi-digit frames.
module seg_pattern_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   value,
    output logic                  value_valid,
    output logic                  pat_err,
    output logic                  sel_err,
    output logic [7:0]            err_count,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        COUNT  = 2'd1,
        HELD   = 2'd2
    } state_t;

    localparam int                SW       = 7 + DIGITS;
    localparam logic [SW-1:0]     SAMP_RST = {7'h7F, {DIGITS{1'b0}}};
    localparam logic [3:0]        CNT_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [DIGITS-1:0] ALL_SET  = '1;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [SW-1:0]         samp_q;
    logic [SW-1:0]         prev_q;
    logic [DIGITS-1:0]     bitmap_q;
    logic [4*DIGITS-1:0]   slots_q;

    logic [DIGITS-1:0]     sel_c;
    logic [6:0]            seg_c;
    logic                  same_c;
    logic                  accept_c;
    logic                  legal_c;
    logic [3:0]            nib_c;
    logic                  none_c;
    logic                  multi_c;
    logic [4*DIGITS-1:0]   slots_d;
    logic [DIGITS-1:0]     bitmap_d;
    logic [7:0]            err_count_d;

    // Returns {legal, nibble}; anything not in the hex font is illegal.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0011000: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b0000011: r = 5'h1B;
            7'b1000110: r = 5'h1C;
            7'b0100001: r = 5'h1D;
            7'b0000110: r = 5'h1E;
            7'b0001110: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        sel_c    = samp_q[DIGITS-1:0];
        seg_c    = samp_q[SW-1:DIGITS];
        same_c   = (samp_q == prev_q);
        // The run becomes long enough on this edge; HELD blocks a second accept.
        accept_c = same_c && (state_q != HELD) && (cnt_q == CNT_LAST);
        {legal_c, nib_c} = decode(seg_c);
        none_c   = (sel_c == '0);
        multi_c  = ((sel_c & (sel_c - DIGITS'(1))) != '0);
        slots_d  = slots_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_c[i]) begin
                slots_d[4*i +: 4] = nib_c;
            end
        end
        bitmap_d    = bitmap_q | sel_c;
        err_count_d = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SETTLE;
            cnt_q       <= 4'd1;
            samp_q      <= SAMP_RST;
            prev_q      <= SAMP_RST;
            bitmap_q    <= '0;
            slots_q     <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            pat_err     <= 1'b0;
            sel_err     <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            samp_q      <= {seg_in, dig_sel};
            prev_q      <= samp_q;
            value_valid <= 1'b0;
            pat_err     <= 1'b0;
            sel_err     <= 1'b0;
            if (!same_c) begin
                state_q <= SETTLE;
                cnt_q   <= 4'd1;
            end else if (accept_c) begin
                state_q <= HELD;
                if (multi_c) begin
                    sel_err   <= 1'b1;
                    err_count <= err_count_d;
                    bitmap_q  <= '0;
                end else if (!none_c) begin
                    if (!legal_c) begin
                        pat_err   <= 1'b1;
                        err_count <= err_count_d;
                        bitmap_q  <= '0;
                    end else begin
                        slots_q <= slots_d;
                        if (bitmap_d == ALL_SET) begin
                            value       <= slots_d;
                            value_valid <= 1'b1;
                            bitmap_q    <= '0;
                        end else begin
                            bitmap_q <= bitmap_d;
                        end
                    end
                end
            end else if (state_q != HELD) begin
                state_q <= COUNT;
                cnt_q   <= cnt_q + 4'd1;
            end
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Bench for seg_pattern_reader: directed vector table, reset/saturation sequences
// and randomized runs checked every cycle against a run-length reference model.
module tb_seg_pattern_reader;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] value;
    logic        value_valid;
    logic        pat_err;
    logic        sel_err;
    logic [7:0]  err_count;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    seg_pattern_reader #(.DIGITS(4), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .value       (value),
        .value_valid (value_valid),
        .pat_err     (pat_err),
        .sel_err     (sel_err),
        .err_count   (err_count),
        .dbg_state_o (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] codes [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model: counts identical consecutive samples; an accept decided
    // after the S-th sample takes effect on the following edge.
    logic [10:0] m_last;
    int          m_run;
    bit          m_pend;
    logic [10:0] m_pend_in;
    int          m_slots [4];
    int          m_bitmap;
    logic [15:0] m_value;
    int          m_err;
    bit          m_valid, m_pat, m_sel;

    int n_valid, n_pat, n_sel;

    typedef struct packed {
        logic [6:0]  seg;
        logic [3:0]  sel;
        int          hold;
        logic [15:0] exp_value;
        logic [7:0]  exp_err;
        int          exp_valid;
        int          exp_pat;
        int          exp_sel;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic [6:0] s, input logic [3:0] d, input int h,
                                input logic [15:0] v, input logic [7:0] e,
                                input int nv, input int np, input int ns);
        vec_t r;
        r.seg = s; r.sel = d; r.hold = h; r.exp_value = v; r.exp_err = e;
        r.exp_valid = nv; r.exp_pat = np; r.exp_sel = ns;
        return r;
    endfunction

    function automatic int decode_ref(input logic [6:0] s);
        for (int n = 0; n < 16; n++) begin
            if (codes[n] == s) return n;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = {7'h7F, 4'h0};
        m_run = 1;
        m_pend = 0;
        m_bitmap = 0;
        m_value = 16'h0;
        m_err = 0;
        m_valid = 0; m_pat = 0; m_sel = 0;
    endtask

    task automatic model_accept(input logic [6:0] s, input logic [3:0] d);
        int idx;
        int n;
        idx = 0;
        if (d == 4'b0) return;
        if ($countones(d) > 1) begin
            m_sel = 1;
            if (m_err < 255) m_err++;
            m_bitmap = 0;
            return;
        end
        for (int i = 0; i < 4; i++) if (d[i]) idx = i;
        n = decode_ref(s);
        if (n < 0) begin
            m_pat = 1;
            if (m_err < 255) m_err++;
            m_bitmap = 0;
            return;
        end
        m_slots[idx] = n;
        m_bitmap = m_bitmap | (1 << idx);
        if (m_bitmap == 15) begin
            m_value = 16'(m_slots[3] * 4096 + m_slots[2] * 256 + m_slots[1] * 16 + m_slots[0]);
            m_valid = 1;
            m_bitmap = 0;
        end
    endtask

    task automatic model_step(input logic [6:0] s, input logic [3:0] d);
        m_valid = 0; m_pat = 0; m_sel = 0;
        if (m_pend) begin
            model_accept(m_pend_in[10:4], m_pend_in[3:0]);
            m_pend = 0;
        end
        if ({s, d} == m_last) m_run++;
        else begin
            m_last = {s, d};
            m_run = 1;
        end
        if (m_run == S) begin
            m_pend = 1;
            m_pend_in = m_last;
        end
    endtask

    task automatic check_outputs();
        chk("value", 32'(value), 32'(m_value));
        chk("value_valid", 32'(value_valid), 32'(m_valid));
        chk("pat_err", 32'(pat_err), 32'(m_pat));
        chk("sel_err", 32'(sel_err), 32'(m_sel));
        chk("err_count", 32'(err_count), 32'(m_err));
    endtask

    task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            seg_in = s;
            dig_sel = d;
            @(posedge clk);
            model_step(s, d);
            #1;
            check_outputs();
            if (value_valid) n_valid++;
            if (pat_err) n_pat++;
            if (sel_err) n_sel++;
        end
    endtask

    initial begin
        int pat_before;
        logic [6:0] rs;
        logic [3:0] rd;
        int r;

        tbl.push_back(mk(7'b1111001, 4'b0001, 6, 16'h0000, 8'd0, 0, 0, 0));
        tbl.push_back(mk(7'b0100100, 4'b0010, 6, 16'h0000, 8'd0, 0, 0, 0));
        tbl.push_back(mk(7'b0110000, 4'b0100, 6, 16'h0000, 8'd0, 0, 0, 0));
        tbl.push_back(mk(7'b0011001, 4'b1000, 6, 16'h4321, 8'd0, 1, 0, 0));
        tbl.push_back(mk(7'b0000000, 4'b0001, 3, 16'h4321, 8'd0, 0, 0, 0));
        tbl.push_back(mk(7'b1000000, 4'b0001, 6, 16'h4321, 8'd0, 0, 0, 0));
        tbl.push_back(mk(7'b1111111, 4'b0000, 6, 16'h4321, 8'd0, 0, 0, 0));
        tbl.push_back(mk(7'b1000000, 4'b0001, 6, 16'h4321, 8'd0, 0, 0, 0));
        tbl.push_back(mk(7'b0001110, 4'b0010, 6, 16'h4321, 8'd0, 0, 0, 0));
        tbl.push_back(mk(7'b0001110, 4'b0100, 6, 16'h4321, 8'd0, 0, 0, 0));
        tbl.push_back(mk(7'b0001110, 4'b1000, 6, 16'hFFF0, 8'd0, 1, 0, 0));
        tbl.push_back(mk(7'b1000000, 4'b0001, 6, 16'hFFF0, 8'd0, 0, 0, 0));
        tbl.push_back(mk(7'b1111001, 4'b0010, 6, 16'hFFF0, 8'd0, 0, 0, 0));
        tbl.push_back(mk(7'b0011001, 4'b1000, 6, 16'hFFF0, 8'd0, 0, 0, 0));
        tbl.push_back(mk(7'b1111111, 4'b0100, 6, 16'hFFF0, 8'd1, 0, 1, 0));
        tbl.push_back(mk(7'b0001000, 4'b0001, 6, 16'hFFF0, 8'd1, 0, 0, 0));
        tbl.push_back(mk(7'b0000011, 4'b0010, 6, 16'hFFF0, 8'd1, 0, 0, 0));
        tbl.push_back(mk(7'b1000110, 4'b0100, 6, 16'hFFF0, 8'd1, 0, 0, 0));
        tbl.push_back(mk(7'b0100001, 4'b1000, 6, 16'hDCBA, 8'd1, 1, 0, 0));
        tbl.push_back(mk(7'b1000000, 4'b0011, 6, 16'hDCBA, 8'd2, 0, 0, 1));
        tbl.push_back(mk(7'b1000000, 4'b0000, 20, 16'hDCBA, 8'd2, 0, 0, 0));

        rst_n = 1'b0;
        seg_in = 7'h7F;
        dig_sel = 4'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            n_valid = 0; n_pat = 0; n_sel = 0;
            drive(tbl[k].seg, tbl[k].sel, tbl[k].hold);
            chk($sformatf("t%0d_value", k), 32'(value), 32'(tbl[k].exp_value));
            chk($sformatf("t%0d_err_count", k), 32'(err_count), 32'(tbl[k].exp_err));
            chk($sformatf("t%0d_valid_pulses", k), 32'(n_valid), 32'(tbl[k].exp_valid));
            chk($sformatf("t%0d_pat_pulses", k), 32'(n_pat), 32'(tbl[k].exp_pat));
            chk($sformatf("t%0d_sel_pulses", k), 32'(n_sel), 32'(tbl[k].exp_sel));
        end

        // Saturation: 300 illegal accepts on top of the two errors already logged.
        pat_before = n_pat;
        for (int k = 0; k < 300; k++) begin
            drive((k % 2 == 0) ? 7'b1111110 : 7'b1111111, 4'b0001, 5);
        end
        chk("sat_err_count", 32'(err_count), 32'd255);
        chk("sat_pat_pulses", 32'(n_pat - pat_before), 32'd300);

        // Reset in the middle of a frame drops the partial digits.
        drive(7'b1000000, 4'b0001, 6);
        drive(7'b1111001, 4'b0010, 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_value_valid", 32'(value_valid), 32'd0);
        chk("rst_pat_err", 32'(pat_err), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        seg_in = 7'h7F;
        dig_sel = 4'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_valid = 0;
        drive(7'b0100100, 4'b0100, 6);
        drive(7'b0110000, 4'b1000, 6);
        chk("post_rst_partial_valid", 32'(n_valid), 32'd0);
        drive(7'b1000000, 4'b0001, 6);
        drive(7'b1111001, 4'b0010, 6);
        chk("post_rst_full_valid", 32'(n_valid), 32'd1);
        chk("post_rst_value", 32'(value), 32'h3210);

        // Randomized runs of mixed length, strobe and pattern legality.
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) rd = 4'b0;
            else if (r == 1) rd = 4'($urandom_range(1, 15));
            else rd = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) rs = codes[$urandom_range(0, 15)];
            else rs = 7'($urandom_range(0, 127));
            drive(rs, rd, $urandom_range(1, 8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
